// File: rtl/sky130_ef_ip__opamp_pkg.sv
// Shared types and helpers for the behavioral op-amp array model.
// Holds the per-channel state encoding and the gain code decoder.
package sky130_ef_ip__opamp_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_STARTUP = 2'd1,
    ST_ACTIVE  = 2'd2
  } opamp_state_e;

  // Absorbs accumulated rounding from repeated SLEW_STEP additions so a ramp
  // lands on its target in the expected number of cycles.
  localparam real SLEW_EPS = 1.0e-9;

  function automatic real gain_of(input logic [1:0] code);
    case (code)
      2'd0:    return 1.0;
      2'd1:    return 10.0;
      2'd2:    return 100.0;
      default: return 1000.0;
    endcase
  endfunction

endpackage

// File: rtl/sky130_ef_ip__opamp_chan.sv
// One amplifier channel: OFF/STARTUP/ACTIVE sequencing, bias-gated startup
// counter and a slew-limited, clipped output.
module sky130_ef_ip__opamp_chan
  import sky130_ef_ip__opamp_pkg::*;
#(
  parameter int  STARTUP_CYC = 16,
  parameter real SLEW_STEP   = 0.1,
  parameter real VMAX        = 3.3,
  parameter real BIAS_MIN    = 0.5
) (
  input  logic       clk,
  input  logic       rstn,
  input  real        inp_i,
  input  real        inn_i,
  input  real        bias_i,
  input  logic       ena_i,
  input  logic [1:0] gain_sel_i,
  output real        out_o,
  output logic       ready_o,
  output logic       sat_o
);

  localparam logic [7:0] LAST_CNT = 8'(STARTUP_CYC - 1);

  opamp_state_e state_q;
  logic [7:0]   cnt_q;
  real          out_q;
  logic         ready_q;
  logic         sat_q;

  real  raw_d;
  real  target_d;
  real  slew_d;
  logic oor_d;
  logic bias_ok_d;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch.
    raw_d     = (inp_i - inn_i) * gain_of(gain_sel_i);
    oor_d     = (raw_d > VMAX) || (raw_d < 0.0);
    bias_ok_d = (bias_i >= BIAS_MIN);
    target_d  = raw_d;
    if (raw_d > VMAX)     target_d = VMAX;
    else if (raw_d < 0.0) target_d = 0.0;
    slew_d = target_d;
    if ((target_d - out_q) > (SLEW_STEP + SLEW_EPS))        slew_d = out_q + SLEW_STEP;
    else if ((out_q - target_d) > (SLEW_STEP + SLEW_EPS))   slew_d = out_q - SLEW_STEP;
  end

  // NOTE: state uses non-blocking assignments; the synchronous reset clears
  // every state element, including the real-valued output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      out_q   <= 0.0;
      ready_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          out_q <= 0.0;
          if (ena_i) begin
            state_q <= ST_STARTUP;
            cnt_q   <= '0;
          end
        end
        ST_STARTUP: begin
          if (!ena_i) begin
            state_q <= ST_OFF;
            out_q   <= 0.0;
          end else if (bias_ok_d) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_ACTIVE;
              ready_q <= 1'b1;
              sat_q   <= oor_d;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_ACTIVE: begin
          if (!ena_i) begin
            state_q <= ST_OFF;
            out_q   <= 0.0;
            ready_q <= 1'b0;
            sat_q   <= 1'b0;
          end else if (!bias_ok_d) begin
            // Bias collapse restarts the warm-up but keeps the last output.
            state_q <= ST_STARTUP;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            sat_q   <= 1'b0;
          end else begin
            out_q <= slew_d;
            sat_q <= oor_d;
          end
        end
        default: begin
          state_q <= ST_OFF;
          out_q   <= 0.0;
          ready_q <= 1'b0;
          sat_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out_o   = out_q;
  assign ready_o = ready_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/sky130_ef_ip__opamp_array.sv
// Behavioral array of independent programmable-gain amplifier channels.
// With FUNCTIONAL=0 the block is an empty shell with undriven outputs.
module sky130_ef_ip__opamp_array #(
  parameter int  FUNCTIONAL  = 1,
  parameter int  NCHAN       = 4,
  parameter int  STARTUP_CYC = 16,
  parameter real SLEW_STEP   = 0.1,
  parameter real VMAX        = 3.3,
  parameter real BIAS_MIN    = 0.5
) (
`ifdef USE_POWER_PINS
  input  logic               vdd,
  input  logic               vss,
  input  logic               dvdd,
  input  logic               dvss,
`endif
  input  logic               clk,
  input  logic               rstn,
  input  real                inp [NCHAN],
  input  real                inn [NCHAN],
  input  real                bias,
  input  logic [NCHAN-1:0]   ena,
  input  logic [2*NCHAN-1:0] gain_sel,
  output real                out [NCHAN],
  output logic [NCHAN-1:0]   ready,
  output logic [NCHAN-1:0]   sat
);

  if (FUNCTIONAL != 0) begin : g_model
    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      sky130_ef_ip__opamp_chan #(
        .STARTUP_CYC (STARTUP_CYC),
        .SLEW_STEP   (SLEW_STEP),
        .VMAX        (VMAX),
        .BIAS_MIN    (BIAS_MIN)
      ) u_chan (
        .clk        (clk),
        .rstn       (rstn),
        .inp_i      (inp[g]),
        .inn_i      (inn[g]),
        .bias_i     (bias),
        .ena_i      (ena[g]),
        .gain_sel_i (gain_sel[2*g +: 2]),
        .out_o      (out[g]),
        .ready_o    (ready[g]),
        .sat_o      (sat[g])
      );
    end
  end

endmodule

// File: tb/tb_sky130_ef_ip__opamp_array.sv
// Directed bench for the op-amp array: reset, startup, bias starvation,
// saturation ramps, per-channel disable and reset during operation.
module tb_sky130_ef_ip__opamp_array;

  localparam int  NCHAN = 4;
  localparam real TOL   = 1.0e-6;

  logic               clk = 1'b0;
  logic               rstn;
  real                inp [NCHAN];
  real                inn [NCHAN];
  real                bias;
  logic [NCHAN-1:0]   ena;
  logic [2*NCHAN-1:0] gain_sel;
  real                out [NCHAN];
  logic [NCHAN-1:0]   ready;
  logic [NCHAN-1:0]   sat;

  int n_assert = 0;
  int n_fail   = 0;

  sky130_ef_ip__opamp_array dut (
    .clk      (clk),
    .rstn     (rstn),
    .inp      (inp),
    .inn      (inn),
    .bias     (bias),
    .ena      (ena),
    .gain_sel (gain_sel),
    .out      (out),
    .ready    (ready),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(2);
    for (int c = 0; c < NCHAN; c++) begin
      n_assert++;
      if (out[c] != 0.0 || ready[c] !== 1'b0 || sat[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset ch%0d: out=%f ready=%b sat=%b, want 0.0/0/0", c, out[c], ready[c], sat[c]);
      end
    end
    ena  = '0;
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_startup_ramp();
    inp[0] = 1.0005; inn[0] = 1.0; gain_sel[1:0] = 2'd3; bias = 1.0; ena[0] = 1'b1;
    tick(1);
    tick(15);
    n_assert++;
    if (ready[0] !== 1'b0 || out[0] != 0.0) begin
      n_fail++;
      $display("FAIL startup_early: ready=%b out=%f, want 0/0.0", ready[0], out[0]);
    end
    tick(1);
    n_assert++;
    if (ready[0] !== 1'b1 || sat[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL startup_ready: ready=%b sat=%b, want 1/0", ready[0], sat[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      n_assert++;
      if (absr(out[0] - 0.1 * k) > TOL) begin
        n_fail++;
        $display("FAIL ramp step%0d: out=%f want %f", k, out[0], 0.1 * k);
      end
    end
    tick(1);
    n_assert++;
    if (absr(out[0] - 0.5) > TOL) begin
      n_fail++;
      $display("FAIL ramp settle: out=%f want 0.5", out[0]);
    end
  endtask

  task automatic test_bias_starvation();
    inp[1] = 0.0; inn[1] = 0.0; gain_sel[3:2] = 2'd0;
    bias = 0.2; ena[1] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      n_assert++;
      if (ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL starve ready1 cyc%0d: got %b want 0", k, ready[1]);
      end
    end
    // Channel 0 shares the bias: it drops to STARTUP but holds its output.
    n_assert++;
    if (ready[0] !== 1'b0 || absr(out[0] - 0.5) > TOL) begin
      n_fail++;
      $display("FAIL starve hold ch0: ready=%b out=%f, want 0/0.5", ready[0], out[0]);
    end
    bias = 1.0;
    tick(15);
    n_assert++;
    if (ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL starve early: ready1=%b want 0", ready[1]);
    end
    tick(1);
    n_assert++;
    if (ready[1] !== 1'b1 || ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL starve recover: ready1=%b ready0=%b, want 1/1", ready[1], ready[0]);
    end
    tick(1);
    n_assert++;
    if (absr(out[0] - 0.5) > TOL) begin
      n_fail++;
      $display("FAIL starve ch0 resume: out=%f want 0.5", out[0]);
    end
  endtask

  task automatic test_saturation();
    inp[3] = 1.01; inn[3] = 1.0; gain_sel[7:6] = 2'd3; ena[3] = 1'b1;
    tick(17);
    n_assert++;
    if (ready[3] !== 1'b1 || sat[3] !== 1'b1 || out[3] != 0.0) begin
      n_fail++;
      $display("FAIL sat active: ready=%b sat=%b out=%f, want 1/1/0.0", ready[3], sat[3], out[3]);
    end
    for (int k = 1; k <= 33; k++) begin
      tick(1);
      n_assert++;
      if (sat[3] !== 1'b1 || absr(out[3] - 0.1 * k) > TOL) begin
        n_fail++;
        $display("FAIL sat up step%0d: sat=%b out=%f want 1/%f", k, sat[3], out[3], 0.1 * k);
      end
    end
    tick(1);
    n_assert++;
    if (absr(out[3] - 3.3) > TOL) begin
      n_fail++;
      $display("FAIL sat clip: out=%f want 3.3", out[3]);
    end
    gain_sel[7:6] = 2'd1;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      n_assert++;
      if (sat[3] !== 1'b0 || absr(out[3] - (3.3 - 0.1 * k)) > TOL) begin
        n_fail++;
        $display("FAIL sat down step%0d: sat=%b out=%f want 0/%f", k, sat[3], out[3], 3.3 - 0.1 * k);
      end
    end
    tick(1);
    n_assert++;
    if (absr(out[3] - 0.1) > TOL) begin
      n_fail++;
      $display("FAIL sat down settle: out=%f want 0.1", out[3]);
    end
  endtask

  task automatic test_disable();
    inp[2] = 1.002; inn[2] = 1.0; gain_sel[5:4] = 2'd3; ena[2] = 1'b1;
    tick(17);
    tick(17);
    n_assert++;
    if (ready[2] !== 1'b1 || absr(out[2] - 1.7) > TOL) begin
      n_fail++;
      $display("FAIL disable pre: ready=%b out=%f, want 1/1.7", ready[2], out[2]);
    end
    ena[2] = 1'b0;
    tick(1);
    n_assert++;
    if (ready[2] !== 1'b0 || out[2] != 0.0 || sat[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable ch2: ready=%b out=%f sat=%b, want 0/0.0/0", ready[2], out[2], sat[2]);
    end
    n_assert++;
    if (ready !== 4'b1011 || absr(out[0] - 0.5) > TOL || absr(out[3] - 0.1) > TOL || absr(out[1]) > TOL) begin
      n_fail++;
      $display("FAIL disable others: ready=%b out0=%f out1=%f out3=%f, want 1011/0.5/0.0/0.1",
               ready, out[0], out[1], out[3]);
    end
  endtask

  task automatic test_reset_mid();
    ena = 4'hF;
    tick(17);
    n_assert++;
    if (ready !== 4'hF) begin
      n_fail++;
      $display("FAIL midrst pre: ready=%b want 1111", ready);
    end
    rstn = 1'b0;
    tick(1);
    for (int c = 0; c < NCHAN; c++) begin
      n_assert++;
      if (out[c] != 0.0 || ready[c] !== 1'b0 || sat[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst ch%0d: out=%f ready=%b sat=%b, want 0.0/0/0", c, out[c], ready[c], sat[c]);
      end
    end
    rstn = 1'b1;
    tick(1);
    tick(15);
    n_assert++;
    if (ready !== 4'h0) begin
      n_fail++;
      $display("FAIL midrst early: ready=%b want 0000", ready);
    end
    tick(1);
    n_assert++;
    if (ready !== 4'hF) begin
      n_fail++;
      $display("FAIL midrst ready: ready=%b want 1111", ready);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    ena      = 4'hF;
    bias     = 1.0;
    gain_sel = '0;
    for (int c = 0; c < NCHAN; c++) begin
      inp[c] = 0.0;
      inn[c] = 0.0;
    end
    test_reset();
    test_startup_ramp();
    test_bias_starvation();
    test_saturation();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
